// File: rtl/rpc_cmd_arbiter.sv
// rpc_cmd_arbiter
// Shares the single downstream RPC command issuer between the refresh timer
// (REF stream) and the frontend (read/write stream). Data normally wins; a
// REF that has been bypassed for max_postpone_i cycles becomes urgent and is
// forced through. After an issued REF all traffic is held off for trfc_i
// cycles so the device can finish its refresh.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   ST_IDLE     | no command held; accept from at most one source
//   ST_ISSUE    | cmd_o presented to the issuer, held until cmd_ready_i
//   ST_REF_WAIT | tRFC window after a REF handshake; everything blocked
module rpc_cmd_arbiter #(
   parameter int CMD_WIDTH  = 19,
   parameter int AGE_WIDTH  = 8,
   parameter int TRFC_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // refresh timer side
   input  logic                  ref_valid_i,
   output logic                  ref_ready_o,
   input  logic [CMD_WIDTH-1:0]  ref_cmd_i,
   // frontend read/write side
   input  logic                  data_valid_i,
   output logic                  data_ready_o,
   input  logic [CMD_WIDTH-1:0]  data_cmd_i,
   // configuration
   input  logic [AGE_WIDTH-1:0]  max_postpone_i,
   input  logic [TRFC_WIDTH-1:0] trfc_i,
   // command issuer side
   output logic                  cmd_valid_o,
   input  logic                  cmd_ready_i,
   output logic [CMD_WIDTH-1:0]  cmd_o,
   output logic                  cmd_is_ref_o,
   // status
   output logic                  ref_blocking_o,
   output logic                  ref_urgent_o
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_ISSUE    = 2'b01,
      ST_REF_WAIT = 2'b10
   } state_t;

   state_t                  state_q;
   logic [AGE_WIDTH-1:0]    age_q;
   logic [TRFC_WIDTH-1:0]   trfc_cnt_q;
   logic [CMD_WIDTH-1:0]    cmd_q;
   logic                    is_ref_q;

   logic                    in_idle;
   logic                    urgent;
   logic                    sel_ref;
   logic                    sel_data;
   logic                    issue_hs;

   // Source selection in IDLE: urgent REF, then data, then a non-urgent REF.
   // Everything is gated by rst_i so all outputs read 0 while reset is held,
   // even before the first reset edge has cleared the state register.
   always_comb begin
      in_idle  = (state_q == ST_IDLE) && !rst_i;
      urgent   = ref_valid_i && (age_q >= max_postpone_i) && !rst_i;
      sel_ref  = in_idle && ref_valid_i && (urgent || !data_valid_i);
      sel_data = in_idle && data_valid_i && !urgent;
      issue_hs = (state_q == ST_ISSUE) && cmd_ready_i && !rst_i;
   end

   // Output drive; the command word and its type come straight from registers.
   always_comb begin
      ref_ready_o    = sel_ref;
      data_ready_o   = sel_data;
      ref_urgent_o   = urgent;
      cmd_valid_o    = (state_q == ST_ISSUE) && !rst_i;
      ref_blocking_o = (state_q == ST_REF_WAIT) && !rst_i;
      cmd_o          = cmd_q;
      cmd_is_ref_o   = is_ref_q;
   end

   // Refresh age: counts cycles a pending REF is passed over, saturating so a
   // long stall can never wrap back below the postponement limit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         age_q <= '0;
      end else if (ref_valid_i && !sel_ref) begin
         if (!(&age_q)) begin
            age_q <= age_q + 1'b1;
         end
      end else begin
         age_q <= '0;
      end
   end

   // Main sequencer: accept, hold for the issuer, then the optional tRFC wait.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         trfc_cnt_q <= '0;
         cmd_q      <= '0;
         is_ref_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sel_ref) begin
                  cmd_q    <= ref_cmd_i;
                  is_ref_q <= 1'b1;
                  state_q  <= ST_ISSUE;
               end else if (sel_data) begin
                  cmd_q    <= data_cmd_i;
                  is_ref_q <= 1'b0;
                  state_q  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (issue_hs) begin
                  // trfc_i is only looked at here, so it may change freely
                  // while a REF is queued or in flight.
                  if (is_ref_q && (trfc_i != '0)) begin
                     trfc_cnt_q <= trfc_i;
                     state_q    <= ST_REF_WAIT;
                  end else begin
                     state_q    <= ST_IDLE;
                  end
               end
            end
            ST_REF_WAIT: begin
               // Leave in the cycle the counter reads 1 so the window is
               // exactly trfc_i cycles long; a 0 is treated the same as 1.
               if (trfc_cnt_q <= TRFC_WIDTH'(1)) begin
                  trfc_cnt_q <= '0;
                  state_q    <= ST_IDLE;
               end else begin
                  trfc_cnt_q <= trfc_cnt_q - 1'b1;
               end
            end
            default: begin
               trfc_cnt_q <= '0;
               state_q    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rpc_cmd_arbiter.sv
// Directed bench for rpc_cmd_arbiter. Accepted commands are queued as they are
// handed to the arbiter and checked against cmd_o at the issuer handshake;
// cycle-level behaviour is checked against hand-derived constants.
module tb_rpc_cmd_arbiter;

   localparam int CW = 19;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          ref_valid_i;
   logic          ref_ready_o;
   logic [CW-1:0] ref_cmd_i;
   logic          data_valid_i;
   logic          data_ready_o;
   logic [CW-1:0] data_cmd_i;
   logic [7:0]    max_postpone_i;
   logic [7:0]    trfc_i;
   logic          cmd_valid_o;
   logic          cmd_ready_i;
   logic [CW-1:0] cmd_o;
   logic          cmd_is_ref_o;
   logic          ref_blocking_o;
   logic          ref_urgent_o;

   int tests = 0;
   int fails = 0;

   logic [CW:0] sb[$];
   logic [CW:0] sb_exp;

   rpc_cmd_arbiter dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .ref_valid_i    (ref_valid_i),
      .ref_ready_o    (ref_ready_o),
      .ref_cmd_i      (ref_cmd_i),
      .data_valid_i   (data_valid_i),
      .data_ready_o   (data_ready_o),
      .data_cmd_i     (data_cmd_i),
      .max_postpone_i (max_postpone_i),
      .trfc_i         (trfc_i),
      .cmd_valid_o    (cmd_valid_o),
      .cmd_ready_i    (cmd_ready_i),
      .cmd_o          (cmd_o),
      .cmd_is_ref_o   (cmd_is_ref_o),
      .ref_blocking_o (ref_blocking_o),
      .ref_urgent_o   (ref_urgent_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle: inputs change 1 time unit after the rising edge, outputs are
   // sampled mid-cycle at the falling edge.
   task automatic step(input logic rst, input logic rv, input logic [CW-1:0] rc,
                       input logic dv, input logic [CW-1:0] dc, input logic rdy);
      @(posedge clk_i);
      #1;
      rst_i        = rst;
      ref_valid_i  = rv;
      ref_cmd_i    = rc;
      data_valid_i = dv;
      data_cmd_i   = dc;
      cmd_ready_i  = rdy;
      #4;
   endtask

   task automatic exp5(input string tag, input logic rr, input logic dr,
                       input logic cv, input logic blk, input logic urg);
      chk({tag, "_ref_ready"},  32'(ref_ready_o),    32'(rr));
      chk({tag, "_data_ready"}, 32'(data_ready_o),   32'(dr));
      chk({tag, "_cmd_valid"},  32'(cmd_valid_o),    32'(cv));
      chk({tag, "_blocking"},   32'(ref_blocking_o), 32'(blk));
      chk({tag, "_urgent"},     32'(ref_urgent_o),   32'(urg));
   endtask

   task automatic expc(input string tag, input logic [CW-1:0] c, input logic isref);
      chk({tag, "_cmd"},    32'(cmd_o),        32'(c));
      chk({tag, "_is_ref"}, 32'(cmd_is_ref_o), 32'(isref));
   endtask

   // Scoreboard: push what a source hands over, pop at the issuer handshake.
   always @(negedge clk_i) begin
      if (rst_i === 1'b0) begin
         if (ref_ready_o === 1'b1)  sb.push_back({1'b1, ref_cmd_i});
         if (data_ready_o === 1'b1) sb.push_back({1'b0, data_cmd_i});
         if (cmd_valid_o === 1'b1 && cmd_ready_i === 1'b1) begin
            chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               sb_exp = sb.pop_front();
               chk("sb_cmd",    32'(cmd_o),        32'(sb_exp[CW-1:0]));
               chk("sb_is_ref", 32'(cmd_is_ref_o), 32'(sb_exp[CW]));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   localparam logic [CW-1:0] RA = 19'h5_1111, DB = 19'h2_2222;
   localparam logic [CW-1:0] R2 = 19'h5_0002, D0 = 19'h1_0A00, D1 = 19'h1_0A01, D2 = 19'h1_0A02;
   localparam logic [CW-1:0] R3 = 19'h5_0003, D3 = 19'h3_3333;
   localparam logic [CW-1:0] D4 = 19'h4_4444, D5 = 19'h4_5555;
   localparam logic [CW-1:0] R5 = 19'h6_0005, D6 = 19'h6_6666;
   localparam logic [CW-1:0] R6 = 19'h7_0006, R7 = 19'h7_0007, D7 = 19'h7_7777;

   initial begin
      rst_i = 1'b1; ref_valid_i = 1'b0; ref_cmd_i = '0; data_valid_i = 1'b0;
      data_cmd_i = '0; cmd_ready_i = 1'b1; max_postpone_i = 8'd8; trfc_i = 8'd4;

      // reset with both sources requesting: nothing may leak out
      step(1, 1, RA, 1, DB, 1); exp5("rst0", 0, 0, 0, 0, 0);
      step(1, 1, RA, 1, DB, 1); exp5("rst1", 0, 0, 0, 0, 0); expc("rst1", '0, 0);
      step(0, 0, RA, 0, DB, 1); exp5("idle0", 0, 0, 0, 0, 0);

      // REF alone, tRFC=4, data waiting behind the window
      step(0, 1, RA, 0, DB, 1); exp5("t1_acc", 1, 0, 0, 0, 0);
      step(0, 0, RA, 1, DB, 1); exp5("t1_iss", 0, 0, 1, 0, 0); expc("t1_iss", RA, 1);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, RA, 1, DB, 1); exp5($sformatf("t1_blk%0d", i), 0, 0, 0, 1, 0);
      end
      step(0, 0, RA, 1, DB, 1); exp5("t1_dacc", 0, 1, 0, 0, 0);
      step(0, 0, RA, 0, DB, 1); exp5("t1_diss", 0, 0, 1, 0, 0); expc("t1_diss", DB, 0);
      step(0, 0, RA, 0, DB, 1); exp5("t1_end", 0, 0, 0, 0, 0);

      // continuous data plus REF, max_postpone=3: REF forced through at c4
      max_postpone_i = 8'd3; trfc_i = 8'd2;
      step(0, 1, R2, 1, D0, 1); exp5("t2_c0", 0, 1, 0, 0, 0);
      step(0, 1, R2, 1, D1, 1); exp5("t2_c1", 0, 0, 1, 0, 0); expc("t2_c1", D0, 0);
      step(0, 1, R2, 1, D1, 1); exp5("t2_c2", 0, 1, 0, 0, 0);
      step(0, 1, R2, 1, D2, 1); exp5("t2_c3", 0, 0, 1, 0, 1); expc("t2_c3", D1, 0);
      step(0, 1, R2, 1, D2, 1); exp5("t2_c4", 1, 0, 0, 0, 1);
      step(0, 0, R2, 1, D2, 1); exp5("t2_c5", 0, 0, 1, 0, 0); expc("t2_c5", R2, 1);
      step(0, 0, R2, 1, D2, 1); exp5("t2_c6", 0, 0, 0, 1, 0);
      step(0, 0, R2, 1, D2, 1); exp5("t2_c7", 0, 0, 0, 1, 0);
      step(0, 0, R2, 1, D2, 1); exp5("t2_c8", 0, 1, 0, 0, 0);
      step(0, 0, R2, 0, D2, 1); exp5("t2_c9", 0, 0, 1, 0, 0); expc("t2_c9", D2, 0);
      step(0, 0, R2, 0, D2, 1); exp5("t2_end", 0, 0, 0, 0, 0);

      // max_postpone=0: REF always urgent, beats data
      max_postpone_i = 8'd0; trfc_i = 8'd3;
      step(0, 1, R3, 1, D3, 1); exp5("t3_c0", 1, 0, 0, 0, 1);
      step(0, 0, R3, 1, D3, 1); exp5("t3_c1", 0, 0, 1, 0, 0); expc("t3_c1", R3, 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, R3, 1, D3, 1); exp5($sformatf("t3_blk%0d", i), 0, 0, 0, 1, 0);
      end
      step(0, 0, R3, 1, D3, 1); exp5("t3_dacc", 0, 1, 0, 0, 0);
      step(0, 0, R3, 0, D3, 1); exp5("t3_diss", 0, 0, 1, 0, 0); expc("t3_diss", D3, 0);
      step(0, 0, R3, 0, D3, 1); exp5("t3_end", 0, 0, 0, 0, 0);

      // backpressure: 5 cycles of cmd_ready_i=0, handshake on the 6th
      max_postpone_i = 8'd50; trfc_i = 8'd0;
      step(0, 0, R3, 1, D4, 1); exp5("t4_acc", 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, R3, 1, D5, 0); exp5($sformatf("t4_bp%0d", i), 0, 0, 1, 0, 0);
         expc($sformatf("t4_bp%0d", i), D4, 0);
      end
      step(0, 0, R3, 1, D5, 1); exp5("t4_hs", 0, 0, 1, 0, 0); expc("t4_hs", D4, 0);
      step(0, 0, R3, 1, D5, 1); exp5("t4_idle", 0, 1, 0, 0, 0);
      step(0, 0, R3, 0, D5, 1); exp5("t4_iss2", 0, 0, 1, 0, 0); expc("t4_iss2", D5, 0);
      step(0, 0, R3, 0, D5, 1); exp5("t4_end", 0, 0, 0, 0, 0);

      // tRFC=0: straight back to IDLE, no blocking pulse
      step(0, 1, R5, 0, D6, 1); exp5("t5_acc", 1, 0, 0, 0, 0);
      step(0, 0, R5, 1, D6, 1); exp5("t5_iss", 0, 0, 1, 0, 0); expc("t5_iss", R5, 1);
      step(0, 0, R5, 1, D6, 1); exp5("t5_idle", 0, 1, 0, 0, 0);
      step(0, 0, R5, 0, D6, 1); exp5("t5_diss", 0, 0, 1, 0, 0); expc("t5_diss", D6, 0);
      step(0, 0, R5, 0, D6, 1); exp5("t5_end", 0, 0, 0, 0, 0);

      // reset in the third tRFC wait cycle (trfc=10)
      max_postpone_i = 8'd1; trfc_i = 8'd10;
      step(0, 1, R6, 0, D7, 1); exp5("t6_acc", 1, 0, 0, 0, 0);
      step(0, 0, R6, 0, D7, 1); exp5("t6_iss", 0, 0, 1, 0, 0); expc("t6_iss", R6, 1);
      step(0, 0, R6, 0, D7, 1); exp5("t6_w1", 0, 0, 0, 1, 0);
      step(0, 0, R6, 0, D7, 1); exp5("t6_w2", 0, 0, 0, 1, 0);
      step(1, 0, R6, 1, D7, 1); exp5("t6_rst", 0, 0, 0, 0, 0);
      trfc_i = 8'd0;
      step(0, 1, R7, 1, D7, 1); exp5("t6_post", 0, 1, 0, 0, 0); expc("t6_post", '0, 0);
      step(0, 1, R7, 0, D7, 1); exp5("t6_diss", 0, 0, 1, 0, 1); expc("t6_diss", D7, 0);
      step(0, 1, R7, 0, D7, 1); exp5("t6_racc", 1, 0, 0, 0, 1);
      step(0, 0, R7, 0, D7, 1); exp5("t6_riss", 0, 0, 1, 0, 0); expc("t6_riss", R7, 1);
      step(0, 0, R7, 0, D7, 1); exp5("t6_end", 0, 0, 0, 0, 0);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rpc_cmd_arbiter.md
# rpc_cmd_arbiter

Arbitrates between the refresh timer's REF command stream and the frontend's read/write command stream for the single downstream RPC command issuer. Data commands normally win. A pending refresh is forced through after a programmable postponement limit. After every issued REF, the arbiter blocks all commands for a programmable tRFC window. The block sits between the refresh timer / frontend command generator and the command-phase FSM.

## Interface
- CMD_WIDTH, 19, width of one RPC command word (both sources and output)
- AGE_WIDTH, 8, width of the refresh-postponement age counter and `max_postpone_i`
- TRFC_WIDTH, 8, width of the tRFC blocking counter and `trfc_i`

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset; one clock, reset synchronous and active-high
- ref_valid_i  in  1  refresh request; held until accepted
- ref_ready_o  out  1  refresh request accepted this cycle
- ref_cmd_i  in  CMD_WIDTH  refresh command word
- data_valid_i  in  1  read/write request; held until accepted
- data_ready_o  out  1  data request accepted this cycle
- data_cmd_i  in  CMD_WIDTH  read/write command word
- max_postpone_i  in  AGE_WIDTH  cycles a pending REF may be bypassed by data; quasi-static
- trfc_i  in  TRFC_WIDTH  blocking cycles after a REF handshake; sampled at the REF output handshake
- cmd_valid_o  out  1  command to issuer valid
- cmd_ready_i  in  1  issuer accepts command
- cmd_o  out  CMD_WIDTH  registered command word
- cmd_is_ref_o  out  1  `cmd_o` is a REF
- ref_blocking_o  out  1  high while in the tRFC window
- ref_urgent_o  out  1  pending REF has reached the postponement limit

## Operation
- FSM states:
  - IDLE: accept from at most one source.
  - ISSUE: hold `cmd_o` until `cmd_ready_i`.
  - REF_WAIT: tRFC countdown.
- Age counter:
  - Increments each cycle that `ref_valid_i`=1 and `ref_ready_o`=0.
  - Clears to 0 when `ref_valid_i`=0 or `ref_ready_o`=1.
  - Saturates at all-ones; no wrap.
- `ref_urgent_o` = `ref_valid_i` && (age >= `max_postpone_i`). With `max_postpone_i`=0, a REF is always urgent.
- IDLE selection, combinational, in priority order:
  - urgent REF wins, so `ref_ready_o`=1;
  - otherwise `data_valid_i` wins, so `data_ready_o`=1;
  - otherwise `ref_valid_i` wins, so `ref_ready_o`=1.
- At most one ready is asserted per cycle.
- On acceptance, the selected command loads into the `cmd_o` register and the source type into `cmd_is_ref_o`. The FSM moves to ISSUE.
- ISSUE:
  - `cmd_valid_o`=1.
  - `cmd_o` and `cmd_is_ref_o` stay stable until `cmd_ready_i`=1.
  - Both source readies are 0.
- On the handshake, the next state depends on `cmd_is_ref_o` and `trfc_i`:
  - if `cmd_is_ref_o`=1 and `trfc_i`≠0: load `trfc_i` into the tRFC counter and go to REF_WAIT;
  - if `cmd_is_ref_o`=1 and `trfc_i`=0: go to IDLE;
  - if `cmd_is_ref_o`=0: go to IDLE.
- REF_WAIT:
  - `ref_blocking_o`=1; both readies are 0; `cmd_valid_o`=0.
  - The counter decrements each cycle; the FSM goes to IDLE in the cycle the counter reads 1.
- The age counter keeps running in ISSUE and REF_WAIT.
- An unused or illegal state encoding returns to IDLE.

## Timing
- Reset (`rst_i`=1 at an edge) forces:
  - state IDLE;
  - age counter and tRFC counter 0;
  - `cmd_o`=0, `cmd_is_ref_o`=0.
- While `rst_i`=1, all outputs read 0: `cmd_valid_o`, `ref_ready_o`, `data_ready_o`, `ref_blocking_o`, `ref_urgent_o`.
- Reset mid-ISSUE or mid-REF_WAIT drops the pending command. The source is not re-accepted until IDLE after reset.
- Latency:
  - A source accepted at cycle t gives `cmd_valid_o`=1 from cycle t+1.
  - Peak throughput is one command per 2 cycles (IDLE→ISSUE→IDLE).
- tRFC window:
  - A REF handshake at cycle t blocks cycles t+1 .. t+`trfc_i`.
  - A new accept is possible at t+`trfc_i`+1.
- `ref_ready_o` and `data_ready_o` are combinational from state, valids and age. Sources must not combinationally depend on ready to raise valid.
- Simultaneous `ref_valid_i` and `data_valid_i` in IDLE with age < `max_postpone_i`: data wins and the age counter increments.

## Test plan
- Only REF with `trfc_i`=4:
  - `ref_ready_o` at t, `cmd_valid_o` with `cmd_is_ref_o`=1 at t+1.
  - With `cmd_ready_i`=1: `ref_blocking_o`=1 for t+2..t+5.
  - A pending data request is accepted at t+6.
- Continuous `data_valid_i` plus `ref_valid_i` from cycle 0, `max_postpone_i`=3:
  - Data accepted at cycles 0 and 2; age reaches 3 at cycle 3.
  - `ref_urgent_o`=1, REF accepted at cycle 4, not data.
- `max_postpone_i`=0, both valid in IDLE: REF accepted first; data accepted after ISSUE plus the tRFC window.
- Backpressure: hold `cmd_ready_i`=0 for 5 cycles in ISSUE.
  - `cmd_o` stays stable; `cmd_valid_o`=1; no source ready asserted.
  - Handshake on cycle 6 returns the FSM to IDLE.
- `trfc_i`=0: a REF handshake returns to IDLE next cycle with no `ref_blocking_o` pulse.
- Reset mid-REF_WAIT (`trfc_i`=10, `rst_i` at wait cycle 3):
  - All outputs 0 next cycle; age counter 0.
  - A new data request is accepted the first cycle after `rst_i` deasserts.
